// File: rtl/mmio_timer_if.sv
// Data-memory bus seen by the memory-mapped timer: address, store strobe/data, load data and window select.
// The processor side drives the master modport; the timer is the slave and returns readdata/sel combinationally.
interface mmio_timer_if;
  logic [31:0] addr;
  logic        memwrite;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        sel;

  modport master (output addr, memwrite, writedata, input readdata, sel);
  modport slave  (input addr, memwrite, writedata, output readdata, sel);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit countdown timer with expiry flag and level irq; prescaler under TIMER_PRESCALE_EN.
// Reads are combinational (0 cycles); stores commit on the clock edge; no backpressure, every access completes.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         rst,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  logic [2:0]  ctrl_q,  ctrl_d;
  logic [31:0] load_q,  load_d;
  logic [31:0] count_q, count_d;
  logic        exp_q,   exp_d;
  logic        wr;
  logic        tick;
  logic [2:0]  off;
  logic [31:0] rd_dat;
  logic        unused_addr_lsb;

  assign bus.sel         = (bus.addr[31:5] == BASE[31:5]);
  assign wr              = bus.sel & bus.memwrite;
  assign off             = bus.addr[4:2];
  assign irq             = exp_q & ctrl_q[2];
  assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [7:0] presc_q, presc_d;
  logic [7:0] pcnt_q,  pcnt_d;

  assign tick = ctrl_q[0] && (pcnt_q == presc_q);

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = 8'd0;
    if (wr && off == 3'd4) presc_d = bus.writedata[7:0];
    // Counter only runs while enabled; hitting PRESC is the tick and wraps it.
    if (ctrl_q[0] && pcnt_q != presc_q) pcnt_d = pcnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= 8'd0;
      pcnt_q  <= 8'd0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick = ctrl_q[0];
`endif

  always_comb begin
    rd_dat = 32'd0;
    if (bus.sel) begin
      case (off)
        3'd0:    rd_dat = {29'd0, ctrl_q};
        3'd1:    rd_dat = load_q;
        3'd2:    rd_dat = count_q;
        3'd3:    rd_dat = {31'd0, exp_q};
`ifdef TIMER_PRESCALE_EN
        3'd4:    rd_dat = {24'd0, presc_q};
`endif
        default: rd_dat = 32'd0;
      endcase
    end
  end

  assign bus.readdata = rd_dat;

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;

    // Clear first so a same-cycle expiry below overrides it.
    if (wr && off == 3'd3 && bus.writedata[0]) exp_d = 1'b0;

    if (tick) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        exp_d = 1'b1;
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    // Register stores take priority over whatever the tick decided.
    if (wr && off == 3'd0) ctrl_d = bus.writedata[2:0];
    if (wr && off == 3'd1) begin
      load_d  = bus.writedata;
      count_d = bus.writedata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= 3'd0;
      load_q  <= 32'd0;
      count_q <= 32'd0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: fixed vector table for the documented sequences, hand corner cases, then random bus
// traffic compared every cycle against a register-level model of the timer rules.
module tb_mmio_timer;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;
  int   errs = 0;
  int   checks = 0;

  mmio_timer_if bus();

  mmio_timer #(.BASE(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_load;
  logic [31:0] m_count;
  logic        m_exp;
  logic [7:0]  m_presc;
  logic [7:0]  m_pc;

  task automatic mreset();
    m_ctrl = 3'd0; m_load = 32'd0; m_count = 32'd0;
    m_exp = 1'b0; m_presc = 8'd0; m_pc = 8'd0;
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a >> 5) == (B >> 5);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (!in_win(a)) return 32'd0;
    case (a[4:2])
      3'd0: return {29'd0, m_ctrl};
      3'd1: return m_load;
      3'd2: return m_count;
      3'd3: return {31'd0, m_exp};
`ifdef TIMER_PRESCALE_EN
      3'd4: return {24'd0, m_presc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer: tick/expiry from the rules, then stores override.
  task automatic mstep(input logic [31:0] a, input logic w, input logic [31:0] d);
    logic wr, tick, expire;
    logic [2:0] o;
    logic [2:0] nctrl;
    logic [31:0] ncount;
    logic nexp;
    wr = in_win(a) && w;
    o  = a[4:2];
`ifdef TIMER_PRESCALE_EN
    tick = m_ctrl[0] && (m_pc == m_presc);
`else
    tick = m_ctrl[0];
`endif
    expire = tick && (m_count == 0);
    ncount = m_count;
    if (tick) ncount = expire ? (m_ctrl[1] ? m_load : 32'd0) : m_count - 1;
    if (wr && o == 3'd1) ncount = d;
    nexp = expire ? 1'b1 : ((wr && o == 3'd3 && d[0]) ? 1'b0 : m_exp);
    nctrl = (expire && !m_ctrl[1]) ? {m_ctrl[2:1], 1'b0} : m_ctrl;
    if (wr && o == 3'd0) nctrl = d[2:0];
    if (!m_ctrl[0]) m_pc = 8'd0;
    else            m_pc = (m_pc == m_presc) ? 8'd0 : m_pc + 8'd1;
`ifdef TIMER_PRESCALE_EN
    if (wr && o == 3'd4) m_presc = d[7:0];
`endif
    if (wr && o == 3'd1) m_load = d;
    m_count = ncount;
    m_exp   = nexp;
    m_ctrl  = nctrl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic sl, output logic iq);
    @(negedge clk);
    bus.addr = a; bus.memwrite = w; bus.writedata = d;
    #1;
    rd = bus.readdata; sl = bus.sel; iq = irq;
    @(posedge clk);
    mstep(a, w, d);
  endtask

  // Cycle whose outputs are checked against the model's pre-edge state.
  task automatic mcyc(input string name, input logic [31:0] a, input logic w, input logic [31:0] d);
    logic [31:0] erd, rd;
    logic esl, eiq, sl, iq;
    erd = mread(a); esl = in_win(a); eiq = m_exp & m_ctrl[2];
    cycle(a, w, d, rd, sl, iq);
    chk({name, "_rd"}, rd, erd);
    chk({name, "_sel"}, {31'd0, sl}, {31'd0, esl});
    chk({name, "_irq"}, {31'd0, iq}, {31'd0, eiq});
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] rd;
    logic        sl;
    logic        iq;
  } vec_t;

  function automatic vec_t v(input logic [31:0] off, input logic w, input logic [31:0] d,
                             input logic [31:0] rd, input logic sl, input logic iq);
    vec_t r;
    r.a = B + off; r.w = w; r.d = d; r.rd = rd; r.sl = sl; r.iq = iq;
    return r;
  endfunction

  vec_t tbl[35];

  initial begin
    logic [31:0] rd;
    logic sl, iq;
    logic [31:0] pseq [8];

    // One-shot, auto-reload, clear/expiry collision, decode, one-shot disable via CTRL write.
    tbl[0]  = v(32'h04, 1, 3,          0, 1, 0);
    tbl[1]  = v(32'h00, 1, 5,          0, 1, 0);
    tbl[2]  = v(32'h08, 0, 0,          3, 1, 0);
    tbl[3]  = v(32'h08, 0, 0,          2, 1, 0);
    tbl[4]  = v(32'h08, 0, 0,          1, 1, 0);
    tbl[5]  = v(32'h08, 0, 0,          0, 1, 0);
    tbl[6]  = v(32'h0C, 0, 0,          1, 1, 1);
    tbl[7]  = v(32'h00, 0, 0,          4, 1, 1);
    tbl[8]  = v(32'h0C, 1, 1,          1, 1, 1);
    tbl[9]  = v(32'h0C, 0, 0,          0, 1, 0);
    tbl[10] = v(32'h04, 1, 2,          3, 1, 0);
    tbl[11] = v(32'h00, 1, 3,          4, 1, 0);
    tbl[12] = v(32'h08, 0, 0,          2, 1, 0);
    tbl[13] = v(32'h08, 0, 0,          1, 1, 0);
    tbl[14] = v(32'h08, 0, 0,          0, 1, 0);
    tbl[15] = v(32'h08, 0, 0,          2, 1, 0);
    tbl[16] = v(32'h08, 0, 0,          1, 1, 0);
    tbl[17] = v(32'h08, 0, 0,          0, 1, 0);
    tbl[18] = v(32'h0C, 0, 0,          1, 1, 0);
    tbl[19] = v(32'h0C, 1, 1,          1, 1, 0);
    tbl[20] = v(32'h0C, 0, 0,          0, 1, 0);
    tbl[21] = v(32'h0C, 0, 0,          1, 1, 0);
    tbl[22] = v(32'h08, 0, 0,          1, 1, 0);
    tbl[23] = v(32'h0C, 1, 1,          1, 1, 0);
    tbl[24] = v(32'h0C, 0, 0,          1, 1, 0);
    tbl[25] = v(32'h08, 1, 32'hDEAD,   1, 1, 0);
    tbl[26] = v(32'h20, 1, 32'hDEAD,   0, 0, 0);
    tbl[27] = v(32'h08, 0, 0,          2, 1, 0);
    tbl[28] = v(32'h18, 0, 0,          0, 1, 0);
    tbl[29] = v(32'h10, 0, 0,          0, 1, 0);
    tbl[30] = v(32'h00, 1, 0,          3, 1, 0);
    tbl[31] = v(32'h0A, 0, 0,          1, 1, 0);
    tbl[32] = v(32'h08, 0, 0,          1, 1, 0);
    tbl[33] = v(32'h0C, 1, 1,          1, 1, 0);
    tbl[34] = v(32'h0C, 0, 0,          0, 1, 0);

    bus.addr = B; bus.memwrite = 1'b0; bus.writedata = 32'd0;
    mreset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int o = 0; o < 8; o++) mcyc($sformatf("reset_off%0d", o), B + o * 4, 0, 0);

    // Get irq high and COUNT=5 while running, then reset asynchronously mid-cycle.
    mcyc("pre_load", B + 32'h04, 1, 1);
    mcyc("pre_ctrl", B + 32'h00, 1, 7);
    mcyc("pre_c1",   B + 32'h08, 0, 0);
    mcyc("pre_c0",   B + 32'h08, 0, 0);
    mcyc("pre_irq",  B + 32'h08, 0, 0);
    mcyc("pre_ld5",  B + 32'h04, 1, 5);
    chk("pre_rst_count", m_count, 32'd5);
    #2 rst = 1'b0;
    bus.memwrite = 1'b0;
    for (int o = 0; o < 5; o++) begin
      bus.addr = B + o * 4;
      #1 chk($sformatf("async_rst_off%0d", o), bus.readdata, 32'd0);
    end
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    mreset();
    @(negedge clk);
    rst = 1'b1;
    mcyc("post_rst_c", B + 32'h08, 0, 0);
    mcyc("post_rst_c2", B + 32'h08, 0, 0);

    for (int i = 0; i < 35; i++) begin
      cycle(tbl[i].a, tbl[i].w, tbl[i].d, rd, sl, iq);
      chk($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_sel", i), {31'd0, sl}, {31'd0, tbl[i].sl});
      chk($sformatf("tbl%0d_irq", i), {31'd0, iq}, {31'd0, tbl[i].iq});
    end

`ifdef TIMER_PRESCALE_EN
    // PRESC=1, LOAD=1: COUNT moves every 2 cycles, reloads every 4.
    pseq[0] = 1; pseq[1] = 1; pseq[2] = 0; pseq[3] = 0;
    pseq[4] = 1; pseq[5] = 1; pseq[6] = 0; pseq[7] = 0;
    cycle(B + 32'h10, 1, 1, rd, sl, iq);
    cycle(B + 32'h04, 1, 1, rd, sl, iq);
    cycle(B + 32'h00, 1, 3, rd, sl, iq);
    for (int i = 0; i < 8; i++) begin
      cycle(B + 32'h08, 0, 0, rd, sl, iq);
      chk($sformatf("presc_count%0d", i), rd, pseq[i]);
    end
    cycle(B + 32'h0C, 0, 0, rd, sl, iq);
    chk("presc_exp", rd, 32'd1);
    cycle(B + 32'h10, 0, 0, rd, sl, iq);
    chk("presc_reg", rd, 32'd1);
`else
    pseq[0] = 0;
    cycle(B + 32'h10, 1, 32'hFF, rd, sl, iq);
    cycle(B + 32'h10, 0, 0, rd, sl, iq);
    chk("presc_absent", rd, pseq[0]);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      int off;
      logic w;
      off = $urandom_range(0, 8);
      a = B + off * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) a = $urandom;
      w = ($urandom_range(0, 2) == 0);
      d = (off == 1) ? $urandom_range(0, 6) : $urandom_range(0, 15);
      if ($urandom_range(0, 19) == 0) d = $urandom;
      mcyc($sformatf("rnd%0d", i), a, w, d);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
